muldiv_unit: RTL and testbench

//  Multi-cycle integer multiply/divide unit that owns the HI/LO special registers.

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle integer multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide run on operand magnitudes; a
// single FIX cycle applies result signs before HI/LO are written.
//
// Handshake: start is sampled only while the FSM is in IDLE (busy=0, done=0) and
// op is 0-5; any other start is dropped, never queued. A multiply/divide raises
// busy from the next cycle and finishes with a one-cycle done pulse, in which
// hi/lo already hold the new result. MTHI/MTLO complete at the accepting edge
// with neither busy nor done.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, next_state;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     opnd;     // multiplicand or divisor magnitude
    logic                 neg_q;    // negate product / quotient
    logic                 neg_r;    // negate remainder
    logic                 is_div;
    logic                 dz;       // divide by zero in flight; acc upper holds raw a

    logic                 is_mul_op, is_div_op, accept, is_signed, sign_a, sign_b, b_zero;
    logic [WIDTH-1:0]     mag_a, mag_b;

    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     quo, rem, fix_hi, fix_lo;

    assign is_mul_op = (op == 3'd0) || (op == 3'd1);
    assign is_div_op = (op == 3'd2) || (op == 3'd3);
    assign accept    = start && (state == S_IDLE) && (op <= 3'd5);
    assign is_signed = (op == 3'd0) || (op == 3'd2);
    assign sign_a    = is_signed && a[WIDTH-1];
    assign sign_b    = is_signed && b[WIDTH-1];
    assign mag_a     = sign_a ? (~a + 1'b1) : a;
    assign mag_b     = sign_b ? (~b + 1'b1) : b;
    assign b_zero    = (b == '0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; a zero divisor skips the iteration entirely
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start && is_mul_op)      next_state = S_MUL;
                else if (start && is_div_op) next_state = b_zero ? S_FIX : S_DIV;
            end
            S_MUL:   if (cnt == LAST) next_state = S_FIX;
            S_DIV:   if (cnt == LAST) next_state = S_FIX;
            S_FIX:   next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy      = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
        done      = (state == S_DONE);
        dbg_state = state;
    end

    // One iteration step of each algorithm plus the sign-fixed final result
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[WIDTH]) div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else                  div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        prod = neg_q ? (~acc + 1'b1) : acc;
        quo  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (dz) begin
            fix_hi = acc[2*WIDTH-1:WIDTH];
            fix_lo = '1;
        end else if (is_div) begin
            fix_hi = rem;
            fix_lo = quo;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    // Datapath: operand capture, iteration, and HI/LO/flag writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        if (op == 3'd4) hi <= a;
                        if (op == 3'd5) lo <= a;
                        if (is_mul_op) begin
                            opnd   <= mag_a;
                            acc    <= {{WIDTH{1'b0}}, mag_b};
                            neg_q  <= sign_a ^ sign_b;
                            neg_r  <= 1'b0;
                            is_div <= 1'b0;
                            dz     <= 1'b0;
                        end
                        if (is_div_op) begin
                            opnd   <= mag_b;
                            acc    <= b_zero ? {a, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, mag_a};
                            neg_q  <= sign_a ^ sign_b;
                            neg_r  <= sign_a;
                            is_div <= 1'b1;
                            dz     <= b_zero;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CW'(1);
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (64-bit integer multiply / divide).
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;
    logic [2:0]   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0]  exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dbz = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference result {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        case (o)
            3'd0: res = 64'(sx * sy);
            3'd1: res = {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Driver: one multiply/divide, with optional ignored start mid-op or in DONE
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input bit disturb, input bit poke_done);
        logic [63:0] e;
        int k, lat;
        bit seen, dz;
        dz  = ((o == 3'd2) || (o == 3'd3)) && (bi == 0);
        lat = dz ? 2 : W + 2;
        exp_q.push_back(model(o, ai, bi));
        @(negedge clk);
        start = 1'b1; op = o; a = ai; b = bi;
        @(posedge clk);
        #1 start = 1'b0; a = $urandom; b = $urandom;
        k = 0; seen = 0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("busy_after_accept", busy, 1);
                check("hi_hold", hi, m_hi);
                check("lo_hold", lo, m_lo);
                check("dbz_cleared", div_by_zero, 0);
            end
            if (done) seen = 1;
            else if (disturb && k == 3) begin
                start = 1'b1; op = 3'd3; a = $urandom; b = '0;
            end else if (disturb && k == 4) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("latency", k, lat);
        e = exp_q.pop_front();
        check("result", {hi, lo}, e);
        check("dbz", div_by_zero, dz);
        m_hi = e[63:32]; m_lo = e[31:0]; m_dbz = dz;
        if (poke_done) begin
            start = 1'b1; op = 3'd5; a = $urandom;
            @(negedge clk);
            start = 1'b0;
            check("done_start_busy", busy, 0);
            check("done_start_lo", lo, m_lo);
        end else begin
            @(negedge clk);
        end
        check("done_one_cycle", done, 0);
    endtask

    task automatic mt(input logic [2:0] o, input logic [W-1:0] v);
        @(negedge clk);
        start = 1'b1; op = o; a = v;
        @(negedge clk);
        start = 1'b0;
        if (o == 3'd4) m_hi = v;
        else m_lo = v;
        m_dbz = 1'b0;
        check("mt_busy", busy, 0);
        check("mt_done", done, 0);
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
        check("mt_dbz", div_by_zero, m_dbz);
    endtask

    task automatic ign(input logic [2:0] o);
        @(negedge clk);
        start = 1'b1; op = o; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", busy, 0);
        check("ign_hi", hi, m_hi);
        check("ign_lo", lo, m_lo);
        check("ign_dbz", div_by_zero, m_dbz);
    endtask

    initial begin
        logic [2:0] ro;
        logic [W-1:0] ra, rb;
        // Reset
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 0, 0);
        check("div_zero_raw_a", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);
        run_op(3'd3, 32'd5, 32'd0, 0, 1);
        check("divu_zero", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        check("divu_zero_flag", div_by_zero, 1);
        ign(3'd6);
        ign(3'd7);
        mt(3'd4, 32'h1234);
        mt(3'd5, 32'h5678);
        run_op(3'd0, 32'h0001_E240, 32'hFFFE_7E33, 1, 0);
        run_op(3'd3, 32'hDEAD_BEEF, 32'h0000_1234, 1, 1);

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        reset = 1'b1;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        repeat (30) begin
            @(negedge clk);
            check("abort_quiet", {busy, done}, 0);
        end
        run_op(3'd0, 32'h0000_0123, 32'hFFFF_FF00, 0, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, ra, rb, ($urandom_range(0, 3) == 0) && !(ro >= 3'd2 && rb == 0),
                   $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
